// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings.
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;
    // 2'd3 is unreachable; the next-state logic steers it back to S_IDLE.

endpackage

// File: rtl/serial_adder_fadd.sv
// Team 1-bit full adder cell; the serial adder reuses one instance every cycle.
module fadd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_p;

    // Propagate term is shared between the sum and the carry.
    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry,
// one bit per clock, LSB first. Result and carry-out are held in output
// registers that change only on the completion edge.
//
// Handshake: start is a request that is only looked at while idle (busy=0
// and done=0); a, b and cin are captured on that same edge and ignored
// otherwise. There is no back-pressure: done is a one-cycle strobe and
// sum/cout stay valid from that strobe until the next completion.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_s;
    logic             w_c;
    logic             w_last;

    assign w_last    = (r_cnt == LAST);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign dbg_state = r_state;

    fadd u_fadd (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; the unused encoding falls back to idle.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:  w_next_state = start ? S_SHIFT : S_IDLE;
            S_SHIFT: w_next_state = w_last ? S_DONE : S_SHIFT;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state; busy and done are exclusive.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture operands when accepted, then shift one bit per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_sum_sh <= '0;
                    end
                end
                S_SHIFT: begin
                    r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + 1'b1;
                    // Publish only on the final bit so no partial sum leaks out.
                    if (w_last) begin
                        r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
                        r_cout <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table on WIDTH=8/2/16 instances,
// held-start sequence, mid-operation reset and random operations.
module tb_serial_adder;
    import serial_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start2 = 1'b0, start16 = 1'b0;
    logic [15:0] a_in = '0, b_in = '0;
    logic        cin_in = 1'b0;

    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic [1:0]  st8;
    logic        busy2, done2, cout2;
    logic [1:0]  sum2;
    logic [1:0]  st2;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;
    logic [1:0]  st16;

    int n_total = 0;
    int n_pass  = 0;

    logic [16:0] exp_q[$];
    logic [16:0] last_res[3];

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[16];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]),
        .cin(cin_in), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .dbg_state(st8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a_in[1:0]), .b(b_in[1:0]),
        .cin(cin_in), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
        .dbg_state(st2)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a_in), .b(b_in),
        .cin(cin_in), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
        .dbg_state(st16)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    endtask

    function automatic int width_of(input int sel);
        case (sel)
            0:       return 8;
            1:       return 2;
            default: return 16;
        endcase
    endfunction

    function automatic logic rd_busy(input int sel);
        case (sel)
            0:       return busy8;
            1:       return busy2;
            default: return busy16;
        endcase
    endfunction

    function automatic logic rd_done(input int sel);
        case (sel)
            0:       return done8;
            1:       return done2;
            default: return done16;
        endcase
    endfunction

    function automatic logic [16:0] rd_res(input int sel);
        case (sel)
            0:       return {8'd0, cout8, sum8};
            1:       return {14'd0, cout2, sum2};
            default: return {cout16, sum16};
        endcase
    endfunction

    function automatic logic [1:0] rd_state(input int sel);
        case (sel)
            0:       return st8;
            1:       return st2;
            default: return st16;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start8  = v;
            1:       start2  = v;
            default: start16 = v;
        endcase
    endtask

    // ---------------- driver ----------------
    // Called at a sample point (#1 after an edge) with the selected DUT idle.
    task automatic op(input int sel, input logic [15:0] ta, input logic [15:0] tb,
                      input logic tcin, input logic [16:0] exp);
        int          n;
        int          overlap;
        int          hold_bad;
        logic [16:0] e;
        set_start(sel, 1'b1);
        a_in   = ta;
        b_in   = tb;
        cin_in = tcin;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        // Operands are don't-care after acceptance; scramble them.
        set_start(sel, 1'b0);
        a_in   = 16'($urandom);
        b_in   = 16'($urandom);
        cin_in = 1'($urandom_range(0, 1));
        n = 0; overlap = 0; hold_bad = 0;
        while (rd_busy(sel) && n < 40) begin
            if (rd_done(sel)) overlap++;
            if (rd_res(sel) != last_res[sel]) hold_bad++;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, width_of(sel));
        chk("busy_done_overlap", overlap, 0);
        chk("result_hold", hold_bad, 0);
        chk("done_high", int'(rd_done(sel)), 1);
        e = exp_q.pop_front();
        chk("result", int'(rd_res(sel)), int'(e));
        last_res[sel] = e;
        @(posedge clk); #1;
        chk("done_one_cycle", int'(rd_done(sel)), 0);
        chk("back_to_idle", int'(rd_state(sel)), int'(S_IDLE));
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        int          n_done;
        int          first_done;
        int          prev;
        int          gap_bad;
        int          res_bad;
        logic [15:0] ra, rb;
        logic        rc;

        vecs[0]  = '{0, 16'h005A, 16'h003C, 1'b0, 17'h00096};
        vecs[1]  = '{0, 16'h00FF, 16'h0001, 1'b0, 17'h00100};
        vecs[2]  = '{0, 16'h00FF, 16'h00FF, 1'b1, 17'h001FF};
        vecs[3]  = '{0, 16'h0000, 16'h0000, 1'b1, 17'h00001};
        vecs[4]  = '{0, 16'h0080, 16'h0080, 1'b0, 17'h00100};
        vecs[5]  = '{0, 16'h00AA, 16'h0055, 1'b1, 17'h00100};
        vecs[6]  = '{0, 16'h0012, 16'h0034, 1'b0, 17'h00046};
        vecs[7]  = '{0, 16'h007F, 16'h0001, 1'b0, 17'h00080};
        vecs[8]  = '{1, 16'h0003, 16'h0003, 1'b1, 17'h00007};
        vecs[9]  = '{1, 16'h0001, 16'h0002, 1'b0, 17'h00003};
        vecs[10] = '{1, 16'h0002, 16'h0002, 1'b0, 17'h00004};
        vecs[11] = '{1, 16'h0000, 16'h0000, 1'b1, 17'h00001};
        vecs[12] = '{2, 16'hFFFF, 16'h0001, 1'b0, 17'h10000};
        vecs[13] = '{2, 16'h1234, 16'h4321, 1'b0, 17'h05555};
        vecs[14] = '{2, 16'h8000, 16'h8000, 1'b1, 17'h10001};
        vecs[15] = '{2, 16'hABCD, 16'h1111, 1'b0, 17'h0BCDE};

        for (int i = 0; i < 3; i++) last_res[i] = '0;

        // Reset state while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("rst_busy", int'(rd_busy(s)), 0);
            chk("rst_done", int'(rd_done(s)), 0);
            chk("rst_result", int'(rd_res(s)), 0);
            chk("rst_state", int'(rd_state(s)), int'(S_IDLE));
        end
        rst_n = 1'b1;

        // Directed table; the first op starts on the first edge after release.
        for (int i = 0; i < 16; i++) begin
            op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);
        end

        // start held high: accepted only in IDLE, done every WIDTH+2 cycles.
        a_in = 16'h0001; b_in = 16'h0002; cin_in = 1'b0; start8 = 1'b1;
        n_done = 0; first_done = -1; prev = -1; gap_bad = 0; res_bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                n_done++;
                if (first_done < 0) first_done = k;
                if (prev >= 0 && (k - prev) != 10) gap_bad++;
                prev = k;
                if ({cout8, sum8} != 9'h003) res_bad++;
            end
            if ((k % 10) <= 8) begin
                a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b1;
            end else begin
                a_in = 16'h0001; b_in = 16'h0002; cin_in = 1'b0;
            end
        end
        start8 = 1'b0;
        chk("held_first_done", first_done, 8);
        chk("held_done_count", n_done, 3);
        chk("held_done_gap", gap_bad, 0);
        chk("held_result", res_bad, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("held_drain_idle", int'(st8), int'(S_IDLE));
        chk("held_last_result", int'({cout8, sum8}), 32'h003);
        last_res[0] = 17'h00003;

        // Reset in the middle of SHIFT.
        start8 = 1'b1; a_in = 16'h005A; b_in = 16'h003C; cin_in = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_busy", int'(busy8), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(busy8), 0);
        chk("async_rst_done", int'(done8), 0);
        chk("async_rst_sum", int'(sum8), 0);
        chk("async_rst_cout", int'(cout8), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) last_res[i] = '0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) n_done++;
        end
        chk("no_done_after_rst", n_done, 0);
        op(0, 16'h005A, 16'h003C, 1'b0, 17'h00096);

        // Random operations on all three widths.
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            op(0, ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc));
        end
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom_range(0, 3));
            rb = 16'($urandom_range(0, 3));
            rc = 1'($urandom_range(0, 1));
            op(1, ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc));
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            op(2, ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc));
        end

        chk("scoreboard_empty", exp_q.size(), 0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
